rca_checker: RTL and testbench
==============================

# rca_checker

Synthesizable response checker for the adder datapaths of the FIR filter. It is the receiving end of the adder stimulus interface: it takes each operand vector presented to an adder under test and computes the golden `{c_out, sum}`. After the adder's pipeline latency it compares that golden value against the adder's outputs, and it accumulates pass/fail counts and the first failing vector for readback. It sits beside any `BIT_WIDTH` adder (RCA, CLA, pipelined variants) in both simulation and on-board self-test.

## Interface
- `BIT_WIDTH`, 16: operand and sum width.
- `LATENCY`, 0: cycles from operand presentation to valid DUT output. Legal range 0..7. 0 means a combinational DUT, sampled in the same cycle.
- `CNT_WIDTH`, 16: width of the pass and fail counters.

- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse. Clears counters and the capture registers, then enters RUN.
- `stop` in 1: pulse. Ends vector acceptance, drains vectors still in flight, then reaches DONE.
- `vec_valid` in 1: the operand vector on `add_1`/`add_2`/`c_in` is applied to the DUT this cycle.
- `add_1`, `add_2` in BIT_WIDTH: operands, as driven to the DUT.
- `c_in` in 1: carry in, as driven to the DUT.
- `dut_sum` in BIT_WIDTH: DUT sum.
- `dut_c_out` in 1: DUT carry out.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.
- `pass_cnt` out CNT_WIDTH: count of matching compares. Saturates at all-ones.
- `fail_cnt` out CNT_WIDTH: count of mismatching compares. Saturates at all-ones.
- `mismatch` out 1: one-cycle pulse per failing compare.
- `first_fail_valid` out 1: a failure has been captured since `start`.
- `first_fail_a`, `first_fail_b` out BIT_WIDTH; `first_fail_cin` out 1: operands of the first failing vector.
- `first_fail_got` out BIT_WIDTH+1: the DUT's `{c_out, sum}` for that vector.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - DRAIN.
  - DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DRAIN on `stop`.
  - DRAIN→DONE once no vector is in flight.
  - DONE→RUN on `start`.
  - `start` in any state clears and enters RUN. `start` takes priority over a simultaneous `stop`.
  - `stop` outside RUN is ignored.
- Acceptance: a vector is accepted only when `vec_valid` is high in RUN. `vec_valid` in IDLE, DRAIN or DONE is ignored.
- Golden value: `exp = add_1 + add_2 + c_in`, computed in BIT_WIDTH+1 bits. The MSB is the expected carry.
- Delay line: `exp`, the operands and a valid bit ride a LATENCY-deep shift register. At tap LATENCY the entry is compared with `{dut_c_out, dut_sum}` as sampled in that cycle.
- Compare result:
  - Match: `pass_cnt`+1.
  - Mismatch: `fail_cnt`+1 and `mismatch` pulses.
  - On the first mismatch only, the `first_fail_*` registers load and `first_fail_valid` sets.
- Counters hold at saturation and never wrap.
- DRAIN: compares continue for entries already in the delay line. With LATENCY=0, DRAIN lasts one cycle.
- Reset mid-operation: all state clears immediately and the delay line is emptied. No compare fires after reset is released until a new `start`.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `mismatch`, `first_fail_valid` = 0.
  - Counters, capture registers and delay-line valids = 0.
- A vector accepted in cycle T is compared using DUT outputs sampled in cycle T+LATENCY.
- Counters, `mismatch` and the capture registers update at the clock edge ending cycle T+LATENCY.
- Throughput: one vector per cycle, with no back-pressure.
- `start` in cycle T:
  - Counters read 0 from T+1.
  - Compares pending from before `start` are discarded.
- `stop` in cycle T with LATENCY=L: `done` rises at the edge ending T+L+1 at the latest. It rises earlier if the delay line is already empty.
- `done` stays high until `start` or `rst`.

## Structure
- Shared package `adder_pkg`:
  - Default BIT_WIDTH.
  - The state enumeration (IDLE/RUN/DRAIN/DONE).
  - The golden-add function used by all adder checkers.
- One sub-module, `rca_check_delay`: a parameterized LATENCY-deep valid-tagged shift register for `{valid, exp, a, b, cin}`. At LATENCY=0 it reduces to wires.
- The top level holds the FSM, the comparator, the counters and the first-fail capture.

## Test plan
- LATENCY=0, correct RCA. After `start`, apply 12+15+0, 12+15+1, 65534+1+0, 65534+1+1, then `stop`.
  - Expected results: 27/c0, 28/c0, 65535/c0, 0/c1.
  - Required: `pass_cnt`=4, `fail_cnt`=0, `done`=1 one cycle after `stop`.
- Fault injection: force `dut_c_out`=0 on the 65534+1+1 vector.
  - Required: `mismatch` pulses once, `fail_cnt`=1.
  - Required: `first_fail_a`=65534, `first_fail_b`=1, `first_fail_cin`=1, `first_fail_got`=17'h00000.
- LATENCY=2 with a 2-stage registered DUT, back-to-back vectors, `stop` in the cycle after the last vector.
  - Required: all 4 vectors pass.
  - Required: `busy` stays high through DRAIN, and `done` rises 3 cycles after `stop`.
- Ignore rules:
  - `vec_valid` while IDLE or DONE leaves the counters at 0.
  - `stop` in IDLE leaves the state at IDLE.
  - `start` and `stop` in the same cycle give RUN with cleared counters.
- Assert `rst` mid-run with 2 vectors in flight (LATENCY=2).
  - Required: all outputs reach their reset values.
  - Required: no counter change after release until `start`.
- CNT_WIDTH=3: apply 10 passing vectors.
  - Required: `pass_cnt` saturates at 7 and does not wrap.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder response checkers: default width, checker
// FSM states and the golden add used as the reference model.
package adder_pkg;

    localparam int DEFAULT_BIT_WIDTH = 16;
    // Widest operand the golden add supports; checkers use BIT_WIDTH < 64.
    localparam int MAX_BIT_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_t;

    // Operands arrive zero-extended to MAX_BIT_WIDTH. The caller keeps the low
    // BIT_WIDTH+1 bits, whose MSB is the carry out.
    function automatic logic [MAX_BIT_WIDTH:0] golden_add(
        input logic [MAX_BIT_WIDTH-1:0] a,
        input logic [MAX_BIT_WIDTH-1:0] b,
        input logic                     cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_BIT_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/rca_check_delay.sv
// LATENCY-deep valid-tagged shift register carrying the golden result and
// operands until the adder under test presents its output.
module rca_check_delay #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             in_flight
);

    generate
        if (LATENCY == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, rst, flush};
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_flight = 1'b0;
        end else begin : g_pipe
            logic [LATENCY-1:0] valid_q;
            logic [WIDTH-1:0]   data_q [LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= '0;
                end else if (flush) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    for (int i = 1; i < LATENCY; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            // NOTE: the payload needs no reset; only the valid tags decide
            // whether an entry is ever looked at.
            always_ff @(posedge clk) begin
                data_q[0] <= in_data;
                for (int i = 1; i < LATENCY; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end

            assign out_valid = valid_q[LATENCY-1];
            assign out_data  = data_q[LATENCY-1];
            assign in_flight = |valid_q;
        end
    endgenerate

endmodule

// File: rtl/rca_checker.sv
// Response checker for BIT_WIDTH adders: golden {c_out, sum}, latency-matched
// compare, saturating pass/fail counters and first-failure capture.
module rca_checker
    import adder_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int LATENCY   = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 vec_valid,
    input  logic [BIT_WIDTH-1:0] add_1,
    input  logic [BIT_WIDTH-1:0] add_2,
    input  logic                 c_in,
    input  logic [BIT_WIDTH-1:0] dut_sum,
    input  logic                 dut_c_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic                 mismatch,
    output logic                 first_fail_valid,
    output logic [BIT_WIDTH-1:0] first_fail_a,
    output logic [BIT_WIDTH-1:0] first_fail_b,
    output logic                 first_fail_cin,
    output logic [BIT_WIDTH:0]   first_fail_got
);

    localparam int ENTRY_W = 3 * BIT_WIDTH + 2;

    chk_state_t             state, state_nxt;
    logic [MAX_BIT_WIDTH-1:0] a_ext, b_ext;
    logic [MAX_BIT_WIDTH:0]   sum_ext;
    logic [BIT_WIDTH:0]     exp_in, tap_exp, dut_got;
    logic [ENTRY_W-1:0]     tap_entry;
    logic [BIT_WIDTH-1:0]   tap_a, tap_b;
    logic                   tap_cin, tap_valid, in_flight;
    logic                   accept, cmp_fire, cmp_match;
    logic                   unused_sum_hi;

    // NOTE: combinational blocks use blocking '=', clocked blocks use '<='.
    always_comb begin
        a_ext                  = '0;
        b_ext                  = '0;
        a_ext[BIT_WIDTH-1:0]   = add_1;
        b_ext[BIT_WIDTH-1:0]   = add_2;
        sum_ext                = golden_add(a_ext, b_ext, c_in);
        exp_in                 = sum_ext[BIT_WIDTH:0];
    end
    assign unused_sum_hi = ^sum_ext[MAX_BIT_WIDTH:BIT_WIDTH+1];

    // A start cycle neither accepts nor scores; the line is flushed instead.
    assign accept = vec_valid && (state == RUN) && !start;

    rca_check_delay #(
        .WIDTH   (ENTRY_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .in_valid  (accept),
        .in_data   ({exp_in, add_1, add_2, c_in}),
        .out_valid (tap_valid),
        .out_data  (tap_entry),
        .in_flight (in_flight)
    );

    assign {tap_exp, tap_a, tap_b, tap_cin} = tap_entry;
    assign dut_got   = {dut_c_out, dut_sum};
    assign cmp_fire  = tap_valid && !start;
    assign cmp_match = (tap_exp == dut_got);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (stop) state_nxt = DRAIN;
                DRAIN:   if (!in_flight) state_nxt = DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            mismatch         <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_a     <= '0;
            first_fail_b     <= '0;
            first_fail_cin   <= 1'b0;
            first_fail_got   <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start) begin
                pass_cnt         <= '0;
                fail_cnt         <= '0;
                first_fail_valid <= 1'b0;
                first_fail_a     <= '0;
                first_fail_b     <= '0;
                first_fail_cin   <= 1'b0;
                first_fail_got   <= '0;
            end else if (cmp_fire) begin
                if (cmp_match) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
                end else begin
                    mismatch <= 1'b1;
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_a     <= tap_a;
                        first_fail_b     <= tap_b;
                        first_fail_cin   <= tap_cin;
                        first_fail_got   <= dut_got;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_checker.sv
// Self-checking bench: three checker instances (LATENCY 0, LATENCY 2, and a
// 3-bit-counter LATENCY 1 build) sharing one stimulus bus.
module tb_rca_checker;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, stop, vec_valid, c_in;
    logic [15:0] add_1, add_2;

    // LATENCY 0 instance: adder output driven straight from the table.
    logic [15:0] l0_sum;
    logic        l0_cout;
    logic        l0_busy, l0_done, l0_mm, l0_ffv, l0_ffc;
    logic [15:0] l0_pass, l0_fail, l0_ffa, l0_ffb;
    logic [16:0] l0_ffg;

    // LATENCY 2 instance: two-stage registered adder model.
    logic [16:0] l2_s1, l2_s2;
    logic        l2_fault;
    logic        l2_busy, l2_done, l2_mm, l2_ffv, l2_ffc;
    logic [15:0] l2_pass, l2_fail, l2_ffa, l2_ffb;
    logic [16:0] l2_ffg;

    // LATENCY 1, CNT_WIDTH 3 instance.
    logic [16:0] c3_q;
    logic        c3_busy, c3_done, c3_mm, c3_ffv, c3_ffc;
    logic [2:0]  c3_pass, c3_fail;
    logic [15:0] c3_ffa, c3_ffb;
    logic [16:0] c3_ffg;

    int total = 0;
    int bad   = 0;

    bit          mon_en = 1'b0;
    bit          sb_q[$];
    logic [15:0] mon_prev_pass, mon_prev_fail;

    always #5 clk = ~clk;

    rca_checker #(.BIT_WIDTH(16), .LATENCY(0), .CNT_WIDTH(16)) u_l0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
        .add_1(add_1), .add_2(add_2), .c_in(c_in),
        .dut_sum(l0_sum), .dut_c_out(l0_cout),
        .busy(l0_busy), .done(l0_done), .pass_cnt(l0_pass), .fail_cnt(l0_fail),
        .mismatch(l0_mm), .first_fail_valid(l0_ffv), .first_fail_a(l0_ffa),
        .first_fail_b(l0_ffb), .first_fail_cin(l0_ffc), .first_fail_got(l0_ffg)
    );

    rca_checker #(.BIT_WIDTH(16), .LATENCY(2), .CNT_WIDTH(16)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
        .add_1(add_1), .add_2(add_2), .c_in(c_in),
        .dut_sum(l2_s2[15:0]), .dut_c_out(l2_s2[16]),
        .busy(l2_busy), .done(l2_done), .pass_cnt(l2_pass), .fail_cnt(l2_fail),
        .mismatch(l2_mm), .first_fail_valid(l2_ffv), .first_fail_a(l2_ffa),
        .first_fail_b(l2_ffb), .first_fail_cin(l2_ffc), .first_fail_got(l2_ffg)
    );

    rca_checker #(.BIT_WIDTH(16), .LATENCY(1), .CNT_WIDTH(3)) u_c3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
        .add_1(add_1), .add_2(add_2), .c_in(c_in),
        .dut_sum(c3_q[15:0]), .dut_c_out(c3_q[16]),
        .busy(c3_busy), .done(c3_done), .pass_cnt(c3_pass), .fail_cnt(c3_fail),
        .mismatch(c3_mm), .first_fail_valid(c3_ffv), .first_fail_a(c3_ffa),
        .first_fail_b(c3_ffb), .first_fail_cin(c3_ffc), .first_fail_got(c3_ffg)
    );

    always @(posedge clk) begin
        l2_s1 <= ({1'b0, add_1} + {1'b0, add_2} + {16'd0, c_in}) ^ {16'd0, l2_fault};
        l2_s2 <= l2_s1;
        c3_q  <= {1'b0, add_1} + {1'b0, add_2} + {16'd0, c_in};
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic v);
        add_1     = a;
        add_2     = b;
        c_in      = cin;
        vec_valid = v;
    endtask

    // Scoreboard on the LATENCY 2 instance: each counter step pops one outcome.
    always @(negedge clk) begin
        if (mon_en) begin
            if (l2_pass == mon_prev_pass + 16'd1 || l2_fail == mon_prev_fail + 16'd1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_compare", 64'd1, 64'd0);
                end else begin
                    check("sb_outcome", {63'd0, (l2_pass == mon_prev_pass + 16'd1)},
                          {63'd0, sb_q.pop_front()});
                end
            end
        end
        mon_prev_pass = l2_pass;
        mon_prev_fail = l2_fail;
    end

    initial begin
        vec_t tbl [4];
        vec_t l2v [4];
        int   wait_cnt;
        logic [2:0] c3_prev;

        tbl[0] = '{a: 16'd12,    b: 16'd15, cin: 1'b0, exp: 17'd27};
        tbl[1] = '{a: 16'd12,    b: 16'd15, cin: 1'b1, exp: 17'd28};
        tbl[2] = '{a: 16'd65534, b: 16'd1,  cin: 1'b0, exp: 17'h0FFFF};
        tbl[3] = '{a: 16'd65534, b: 16'd1,  cin: 1'b1, exp: 17'h10000};

        l2v[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, exp: 17'h05555};
        l2v[1] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, exp: 17'h1FFFF};
        l2v[2] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, exp: 17'h10000};
        l2v[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, exp: 17'h00001};

        rst = 1'b1; start = 1'b0; stop = 1'b0; l2_fault = 1'b0;
        l0_sum = '0; l0_cout = 1'b0;
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst_busy", {63'd0, l0_busy}, 64'd0);
        check("rst_done", {63'd0, l0_done}, 64'd0);
        check("rst_pass", {48'd0, l0_pass}, 64'd0);
        check("rst_fail", {48'd0, l0_fail}, 64'd0);
        check("rst_mm",   {63'd0, l0_mm},   64'd0);
        check("rst_ffv",  {63'd0, l0_ffv},  64'd0);
        check("rst_ffg",  {47'd0, l0_ffg},  64'd0);

        // Ignore rules in IDLE
        drive(16'd12, 16'd15, 1'b0, 1'b1);
        l0_sum = 16'd27; l0_cout = 1'b0;
        tick(); tick();
        check("idle_vec_pass", {48'd0, l0_pass}, 64'd0);
        vec_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("idle_stop_busy", {63'd0, l0_busy}, 64'd0);
        check("idle_stop_done", {63'd0, l0_done}, 64'd0);

        // LATENCY 0 table run, clean then with a carry fault on the last vector
        for (int run = 0; run < 2; run++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_clear_pass", {48'd0, l0_pass}, 64'd0);
            check("start_busy", {63'd0, l0_busy}, 64'd1);
            for (int i = 0; i < 4; i++) begin
                bit fault;
                fault = (run == 1) && (i == 3);
                drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
                l0_sum  = tbl[i].exp[15:0];
                l0_cout = fault ? 1'b0 : tbl[i].exp[16];
                tick();
                check("l0_mismatch", {63'd0, l0_mm}, {63'd0, fault});
                check("l0_pass_run", {48'd0, l0_pass}, (fault ? 64'd3 : 64'(i + 1)));
            end
            vec_valid = 1'b0;
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("l0_drain_busy", {63'd0, l0_busy}, 64'd1);
            check("l0_drain_done", {63'd0, l0_done}, 64'd0);
            check("l0_mm_one_cycle", {63'd0, l0_mm}, 64'd0);
            tick();
            check("l0_done", {63'd0, l0_done}, 64'd1);
            check("l0_done_busy", {63'd0, l0_busy}, 64'd0);
            check("l0_fail_final", {48'd0, l0_fail}, (run == 1) ? 64'd1 : 64'd0);
        end
        check("ff_valid", {63'd0, l0_ffv}, 64'd1);
        check("ff_a",   {48'd0, l0_ffa}, 64'd65534);
        check("ff_b",   {48'd0, l0_ffb}, 64'd1);
        check("ff_cin", {63'd0, l0_ffc}, 64'd1);
        check("ff_got", {47'd0, l0_ffg}, 64'h00000);

        // Ignore rules in DONE
        drive(16'd1, 16'd1, 1'b0, 1'b1);
        l0_sum = 16'd2; l0_cout = 1'b0;
        stop = 1'b1;
        tick(); tick();
        stop = 1'b0;
        vec_valid = 1'b0;
        check("done_vec_pass", {48'd0, l0_pass}, 64'd3);
        check("done_hold", {63'd0, l0_done}, 64'd1);

        // LATENCY 2: clean run, then a run with one corrupted sum
        for (int run = 0; run < 2; run++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            mon_en = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bit fault;
                fault = (run == 1) && (i == 1);
                drive(l2v[i].a, l2v[i].b, l2v[i].cin, 1'b1);
                l2_fault = fault;
                sb_q.push_back(!fault);
                tick();
            end
            l2_fault = 1'b0;
            vec_valid = 1'b0;
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("l2_drain_busy1", {62'd0, l2_busy, l2_done}, 64'b10);
            tick();
            check("l2_drain_busy2", {62'd0, l2_busy, l2_done}, 64'b10);
            wait_cnt = 0;
            while (!l2_done && wait_cnt < 10) begin
                tick();
                wait_cnt++;
            end
            check("l2_done_delay", 64'(wait_cnt), 64'd1);
            check("l2_done_busy", {63'd0, l2_busy}, 64'd0);
            check("l2_pass", {48'd0, l2_pass}, (run == 1) ? 64'd3 : 64'd4);
            check("l2_fail", {48'd0, l2_fail}, (run == 1) ? 64'd1 : 64'd0);
            mon_en = 1'b0;
        end
        check("l2_ff_a",   {48'd0, l2_ffa}, 64'hFFFF);
        check("l2_ff_b",   {48'd0, l2_ffb}, 64'hFFFF);
        check("l2_ff_cin", {63'd0, l2_ffc}, 64'd1);
        check("l2_ff_got", {47'd0, l2_ffg}, 64'h1FFFE);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        // start and stop together: RUN with cleared counters
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", {63'd0, l0_busy}, 64'd1);
        check("ss_pass", {48'd0, l0_pass}, 64'd0);
        check("ss_fail", {48'd0, l0_fail}, 64'd0);
        check("ss_ffv",  {63'd0, l0_ffv},  64'd0);
        tick();
        check("ss_still_run", {62'd0, l0_busy, l0_done}, 64'b10);

        // Reset with two vectors in flight on the LATENCY 2 instance
        for (int i = 0; i < 4; i++) begin
            drive(l2v[i].a, l2v[i].b, l2v[i].cin, 1'b1);
            tick();
        end
        check("pre_rst_pass", {48'd0, l2_pass}, 64'd2);
        vec_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_mid_busy", {63'd0, l2_busy}, 64'd0);
        check("rst_mid_pass", {48'd0, l2_pass}, 64'd0);
        check("rst_mid_ffv",  {63'd0, l2_ffv},  64'd0);
        tick();
        rst = 1'b0;
        drive(16'd3, 16'd4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        vec_valid = 1'b0;
        check("post_rst_pass", {48'd0, l2_pass}, 64'd0);
        check("post_rst_fail", {48'd0, l2_fail}, 64'd0);
        check("post_rst_idle", {62'd0, l2_busy, l2_done}, 64'b00);

        // Saturation of a 3-bit pass counter
        start = 1'b1;
        tick();
        start = 1'b0;
        c3_prev = c3_pass;
        for (int i = 0; i < 10; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            tick();
            check("c3_no_wrap", {63'd0, (c3_pass >= c3_prev)}, 64'd1);
            c3_prev = c3_pass;
        end
        vec_valid = 1'b0;
        tick(); tick();
        check("c3_pass_sat", {61'd0, c3_pass}, 64'd7);
        check("c3_fail", {61'd0, c3_fail}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
